// File: rtl/pkt_mbst_arb_pkg.sv
// Shared types and default constants for the multi-burst packet arbiter.
package pkt_mbst_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_STALL_MAX  = 1024;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/pkt_mbst_arb_if.sv
// Packet bus between the requesters, the arbiter and the downstream sink.
interface pkt_mbst_arb_if
    import pkt_mbst_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS
);
    localparam int SW = $clog2(NUM_PORTS);

    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_sop;
    logic [NUM_PORTS-1:0]            in_eop;
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_zero;
    logic [NUM_PORTS-1:0]            in_ready;

    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_sop;
    logic                            out_eop;
    logic                            out_valid;
    logic                            out_zero;
    logic [SW-1:0]                   out_src;
    logic                            out_ready;

    modport master (
        output in_data, in_sop, in_eop, in_valid, in_zero, out_ready,
        input  in_ready, out_data, out_sop, out_eop, out_valid,
        input  out_zero, out_src
    );

    modport slave (
        input  in_data, in_sop, in_eop, in_valid, in_zero, out_ready,
        output in_ready, out_data, out_sop, out_eop, out_valid,
        output out_zero, out_src
    );

endinterface

// File: rtl/pkt_mbst_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer.
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [SW-1:0] o_idx
);

    logic [SW-1:0] w_j;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_j     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_j = SW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/pkt_mbst_arb.sv
// Packet arbiter: round-robin grant locked from sop to eop across bursts,
// single output register, stall and orphan-beat error flags.
module pkt_mbst_arb
    import pkt_mbst_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int STALL_MAX  = DEF_STALL_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_mbst_arb_if.slave        bus,
    input  logic                 err_clr,
    output logic                 err_stall,
    output logic [NUM_PORTS-1:0] err_orphan
);

    localparam int SW = $clog2(NUM_PORTS);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [SW-1:0]           r_gnt;
    logic [SW-1:0]           r_rr_ptr;

    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_sop;
    logic                    r_out_eop;
    logic                    r_out_valid;
    logic                    r_out_zero;
    logic [SW-1:0]           r_out_src;

    logic [CNT_W-1:0]        r_idle_cnt;
    logic                    r_err_stall;
    logic [NUM_PORTS-1:0]    r_err_orphan;

    logic [NUM_PORTS-1:0]    w_req;
    logic [NUM_PORTS-1:0]    w_pick_gnt;
    logic [SW-1:0]           w_pick_idx;
    logic                    w_pick_any;
    logic [NUM_PORTS-1:0]    w_gnt_mask;
    logic                    w_rdy;
    logic                    w_acc;
    logic                    w_g_valid;
    logic                    w_g_sop;
    logic                    w_g_eop;
    logic                    w_g_zero;
    logic [DATA_WIDTH-1:0]   w_g_data;
    logic                    w_stall_set;
    logic [NUM_PORTS-1:0]    w_orph_set;

    assign w_req      = bus.in_valid & bus.in_sop;
    assign w_pick_any = |w_pick_gnt;

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    assign w_g_valid = bus.in_valid[r_gnt];
    assign w_g_sop   = bus.in_sop[r_gnt];
    assign w_g_eop   = bus.in_eop[r_gnt];
    assign w_g_zero  = bus.in_zero[r_gnt];
    assign w_g_data  = bus.in_data[r_gnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_rdy     = bus.out_ready | ~r_out_valid;

    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = '0;
        w_gnt_mask   = '0;
        w_acc        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) w_state_nxt = XFER;
            end
            XFER: begin
                w_gnt_mask[r_gnt]   = 1'b1;
                bus.in_ready[r_gnt] = w_rdy;
                w_acc               = w_g_valid & w_rdy;
                if (w_acc && w_g_eop) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_pick_any)
                r_gnt <= w_pick_idx;
            if (w_acc && w_g_eop)
                r_rr_ptr <= (r_gnt == SW'(NUM_PORTS - 1)) ? '0 : r_gnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_acc) begin
            r_out_data  <= w_g_data;
            r_out_sop   <= w_g_sop;
            r_out_eop   <= w_g_eop;
            r_out_valid <= 1'b1;
            r_out_zero  <= w_g_zero;
            r_out_src   <= r_gnt;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flag fires only on the step into STALL_MAX, so a saturated count can be cleared.
    assign w_stall_set = (r_state == XFER) & ~w_g_valid &
                         (r_idle_cnt == CNT_W'(STALL_MAX - 1));
    assign w_orph_set  = bus.in_valid & ~bus.in_sop & ~w_gnt_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != XFER || w_acc) begin
            r_idle_cnt <= '0;
        end else if (!w_g_valid && r_idle_cnt != CNT_W'(STALL_MAX)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_stall  <= 1'b0;
            r_err_orphan <= '0;
        end else begin
            r_err_stall  <= (r_err_stall & ~err_clr) | w_stall_set;
            r_err_orphan <= (r_err_orphan & ~{NUM_PORTS{err_clr}}) | w_orph_set;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_valid = r_out_valid;
    assign bus.out_zero  = r_out_zero;
    assign bus.out_src   = r_out_src;
    assign err_stall     = r_err_stall;
    assign err_orphan    = r_err_orphan;

endmodule

// File: tb/tb_pkt_mbst_arb.sv
// Directed bench for pkt_mbst_arb: per-port beat queues feed the bus,
// a monitor records transferred output beats for comparison.
module tb_pkt_mbst_arb;
    import pkt_mbst_arb_pkg::*;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int SM = 8;

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          sop;
        bit          eop;
        bit          zero;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic          err_stall;
    logic [NP-1:0] err_orphan;

    beat_t         q[NP][$];
    logic [31:0]   obs[$];
    logic [31:0]   ex[$];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    pkt_mbst_arb_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    pkt_mbst_arb #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .STALL_MAX  (SM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .err_stall  (err_stall),
        .err_orphan (err_orphan)
    );

    function automatic logic [31:0] mk(int src, logic [7:0] d,
                                       bit s, bit e, bit z);
        return {19'd0, z, s, e, 2'(src), d};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pkt(int p, logic [7:0] d, bit s, bit e, bit z);
        q[p].push_back('{1'b1, d, s, e, z});
    endtask

    task automatic gap(int p, int n);
        for (int k = 0; k < n; k++) q[p].push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic cmp_obs(string tag);
        chk({tag, "_n"}, obs.size(), ex.size());
        for (int k = 0; k < ex.size(); k++)
            chk(tag, (k < obs.size()) ? obs[k] : 32'hdead_beef, ex[k]);
        obs.delete();
        ex.delete();
    endtask

    task automatic wait_out(logic [7:0] d, int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_data == d) && n < lim);
        chk("wait_out", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, d});
    endtask

    // Source driver and output monitor
    initial begin
        logic [NP-1:0] acc;
        bus.in_data  = '0;
        bus.in_sop   = '0;
        bus.in_eop   = '0;
        bus.in_valid = '0;
        bus.in_zero  = '0;
        forever begin
            @(negedge clk);
            acc = '0;
            if (!rst) begin
                for (int i = 0; i < NP; i++)
                    acc[i] = bus.in_valid[i] & bus.in_ready[i];
                if (bus.out_valid && bus.out_ready)
                    obs.push_back(mk(int'(bus.out_src), bus.out_data,
                                     bus.out_sop, bus.out_eop, bus.out_zero));
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (q[i].size() > 0 && (!q[i][0].v || acc[i]))
                    void'(q[i].pop_front());
                if (q[i].size() > 0) begin
                    bus.in_valid[i]         = q[i][0].v;
                    bus.in_sop[i]           = q[i][0].sop;
                    bus.in_eop[i]           = q[i][0].eop;
                    bus.in_zero[i]          = q[i][0].zero;
                    bus.in_data[i*DW +: DW] = q[i][0].d;
                end else begin
                    bus.in_valid[i] = 1'b0;
                    bus.in_sop[i]   = 1'b0;
                    bus.in_eop[i]   = 1'b0;
                    bus.in_zero[i]  = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_src", bus.out_src, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_stall", err_stall, 0);
        chk("rst_orphan", err_orphan, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ports 0 and 2 together: port 0 wins from reset pointer
        pkt(0, 8'h10, 1, 0, 0); pkt(0, 8'h11, 0, 0, 0); pkt(0, 8'h12, 0, 1, 0);
        pkt(2, 8'h20, 1, 0, 0); pkt(2, 8'h21, 0, 0, 0); pkt(2, 8'h22, 0, 1, 0);
        repeat (16) @(negedge clk);
        ex.push_back(mk(0, 8'h10, 1, 0, 0));
        ex.push_back(mk(0, 8'h11, 0, 0, 0));
        ex.push_back(mk(0, 8'h12, 0, 1, 0));
        ex.push_back(mk(2, 8'h20, 1, 0, 0));
        ex.push_back(mk(2, 8'h21, 0, 0, 0));
        ex.push_back(mk(2, 8'h22, 0, 1, 0));
        cmp_obs("rr_order");

        // Port 1 burst with a 5-cycle gap; port 3 requests inside the gap
        pkt(1, 8'h40, 1, 0, 0); pkt(1, 8'h41, 0, 0, 0);
        gap(1, 5);
        pkt(1, 8'h42, 0, 1, 0);
        gap(3, 3);
        pkt(3, 8'h50, 1, 0, 0); pkt(3, 8'h51, 0, 1, 0);
        repeat (20) @(negedge clk);
        ex.push_back(mk(1, 8'h40, 1, 0, 0));
        ex.push_back(mk(1, 8'h41, 0, 0, 0));
        ex.push_back(mk(1, 8'h42, 0, 1, 0));
        ex.push_back(mk(3, 8'h50, 1, 0, 0));
        ex.push_back(mk(3, 8'h51, 0, 1, 0));
        cmp_obs("burst_gap");
        chk("gap_stall", err_stall, 0);
        chk("gap_orphan", err_orphan, 0);

        // Downstream backpressure for 4 cycles mid-packet
        pkt(0, 8'h60, 1, 0, 0); pkt(0, 8'h61, 0, 0, 0);
        pkt(0, 8'h62, 0, 0, 0); pkt(0, 8'h63, 0, 1, 0);
        wait_out(8'h61, 20);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("hold_data", bus.out_data, 8'h62);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        ex.push_back(mk(0, 8'h60, 1, 0, 0));
        ex.push_back(mk(0, 8'h61, 0, 0, 0));
        ex.push_back(mk(0, 8'h62, 0, 0, 0));
        ex.push_back(mk(0, 8'h63, 0, 1, 0));
        cmp_obs("bp");

        // Granted port idles mid-packet long enough to trip the stall flag
        pkt(1, 8'h70, 1, 0, 0);
        gap(1, 12);
        pkt(1, 8'h71, 0, 1, 0);
        wait_out(8'h70, 20);
        repeat (7) @(negedge clk);
        chk("stall_pre", err_stall, 0);
        @(negedge clk);
        chk("stall_set", err_stall, 1);
        chk("stall_gnt", bus.in_ready, 4'b0010);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(negedge clk);
        chk("stall_hold", err_stall, 1);
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("stall_clr", err_stall, 0);
        repeat (8) @(negedge clk);
        ex.push_back(mk(1, 8'h70, 1, 0, 0));
        ex.push_back(mk(1, 8'h71, 0, 1, 0));
        cmp_obs("stall_pkt");
        chk("stall_after", err_stall, 0);

        // Port 2 presents a beat without sop while idle
        pkt(2, 8'h80, 0, 1, 0);
        repeat (4) @(negedge clk);
        chk("orph_flag", err_orphan, 4'b0100);
        chk("orph_ready", bus.in_ready, 0);
        chk("orph_valid", bus.out_valid, 0);
        chk("orph_out", obs.size(), 0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("orph_setwins", err_orphan, 4'b0100);
        q[2].delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("orph_clr", err_orphan, 0);
        chk("orph_out2", obs.size(), 0);

        // Reset during beat 2 of a 4-beat packet on port 3
        pkt(3, 8'h90, 1, 0, 0); pkt(3, 8'h91, 0, 0, 0);
        pkt(3, 8'h92, 0, 0, 0); pkt(3, 8'h93, 0, 1, 0);
        wait_out(8'h91, 20);
        rst = 1'b1;
        for (int i = 0; i < NP; i++) q[i].delete();
        @(negedge clk);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_data", bus.out_data, 0);
        chk("mrst_src", bus.out_src, 0);
        chk("mrst_eop", bus.out_eop, 0);
        chk("mrst_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        obs.delete();

        // Pointer back at 0: port 0 must beat port 2
        pkt(0, 8'hA0, 1, 1, 0);
        pkt(2, 8'hA2, 1, 1, 1);
        repeat (10) @(negedge clk);
        ex.push_back(mk(0, 8'hA0, 1, 1, 0));
        ex.push_back(mk(2, 8'hA2, 1, 1, 1));
        cmp_obs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
